// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes, FSM states and counter sizing.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIN  = 2'b10
    } mdu_state_e;

    function automatic int mdu_cnt_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    localparam int MDU_CNT_W = mdu_cnt_w(MDU_WIDTH);

endpackage

// File: rtl/mdu_divider.sv
// One restoring-divide step: shift the next dividend bit into the remainder and subtract the divisor if it fits.
module mdu_divider
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    assign shifted = {rem_i, quo_i[WIDTH-1]};
    assign diff    = shifted - {1'b0, divisor_i};

    // diff[WIDTH] is the borrow: set means the divisor did not fit, so restore.
    assign rem_o = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign quo_o = {quo_i[WIDTH-2:0], ~diff[WIDTH]};

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers (shift-add multiply, restoring divide).
// Define MDU_DIV_EN to build the divider; without it DIV/DIVU just pulse done_o and leave HI/LO alone.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] rs_data_i,
    input  logic [WIDTH-1:0] rt_data_i,
    input  logic             hi_we_i,
    input  logic             lo_we_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CNT_W = mdu_cnt_w(WIDTH);

    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_if_wide(input logic [2*WIDTH-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    mdu_state_e         state;
    logic [CNT_W-1:0]   count;
    logic               done_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic [WIDTH-1:0]   opb;
    logic [2*WIDTH-1:0] acc;
    logic               neg_lo;

    logic signed [WIDTH-1:0] rs_s;
    logic signed [WIDTH-1:0] rt_s;
    logic                    is_signed;
    logic                    op_is_div;
    logic                    rs_neg;
    logic                    rt_neg;
    logic [WIDTH-1:0]        rs_mag;
    logic [WIDTH-1:0]        rt_mag;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] step_next;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    assign rs_s      = rs_data_i;
    assign rt_s      = rt_data_i;
    assign is_signed = (op_i == OP_MULT) || (op_i == OP_DIV);
    assign op_is_div = (op_i == OP_DIV) || (op_i == OP_DIVU);
    assign rs_neg    = is_signed && (rs_s < 0);
    assign rt_neg    = is_signed && (rt_s < 0);
    assign rs_mag    = neg_if(rs_data_i, rs_neg);
    assign rt_mag    = neg_if(rt_data_i, rt_neg);

    // Multiply step: acc = {partial product, remaining multiplier bits}, shifted right each cycle.
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opb};
    assign mul_next = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};

`ifdef MDU_DIV_EN
    logic             is_div;
    logic             neg_hi;
    logic             div_zero;
    logic [WIDTH-1:0] div_rem;
    logic [WIDTH-1:0] div_quo;

    mdu_divider #(.WIDTH(WIDTH)) u_divider (
        .rem_i     (acc[2*WIDTH-1:WIDTH]),
        .quo_i     (acc[WIDTH-1:0]),
        .divisor_i (opb),
        .rem_o     (div_rem),
        .quo_o     (div_quo)
    );

    assign step_next = is_div ? {div_rem, div_quo} : mul_next;
`else
    assign step_next = mul_next;
`endif

    always_comb begin
        {res_hi, res_lo} = neg_if_wide(acc, neg_lo);
`ifdef MDU_DIV_EN
        if (is_div) begin
            res_hi = neg_if(acc[2*WIDTH-1:WIDTH], neg_hi);
            res_lo = div_zero ? '1 : neg_if(acc[WIDTH-1:0], neg_lo);
        end
`endif
    end

    // Control and architectural HI/LO
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state  <= S_IDLE;
            count  <= '0;
            done_r <= 1'b0;
            hi_r   <= '0;
            lo_r   <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (hi_we_i) hi_r <= wdata_i;
                    if (lo_we_i) lo_r <= wdata_i;
                    if (start_i) begin
`ifdef MDU_DIV_EN
                        state <= S_CALC;
                        count <= '0;
`else
                        if (op_is_div) begin
                            done_r <= 1'b1;
                        end else begin
                            state <= S_CALC;
                            count <= '0;
                        end
`endif
                    end
                end
                S_CALC: begin
                    count <= count + 1'b1;
                    if (count == CNT_W'(WIDTH - 1)) begin
                        state <= S_FIN;
                        count <= '0;
                    end
                end
                S_FIN: begin
                    hi_r   <= res_hi;
                    lo_r   <= res_lo;
                    done_r <= 1'b1;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Operand latch and iteration datapath
    always_ff @(posedge clk_i) begin
        if (state == S_IDLE && start_i) begin
            opb    <= op_is_div ? rt_mag : rs_mag;
            acc    <= {{WIDTH{1'b0}}, (op_is_div ? rs_mag : rt_mag)};
            neg_lo <= rs_neg ^ rt_neg;
`ifdef MDU_DIV_EN
            is_div   <= op_is_div;
            neg_hi   <= rs_neg;
            div_zero <= (rt_data_i == '0);
`endif
        end else if (state == S_CALC) begin
            acc <= step_next;
        end
    end

    assign busy_o = (state != S_IDLE);
    assign done_o = done_r;
    assign hi_o   = hi_r;
    assign lo_o   = lo_r;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit; results are checked by a scoreboard popped on done_o.
module tb_mul_div_unit;

    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;
`ifdef MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        start_i = 1'b0;
    logic [1:0]  op_i = 2'b00;
    logic [31:0] rs_data_i = '0;
    logic [31:0] rt_data_i = '0;
    logic        hi_we_i = 1'b0;
    logic        lo_we_i = 1'b0;
    logic [31:0] wdata_i = '0;
    logic        busy_o;
    logic        done_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    logic [63:0] sb[$];
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    mul_div_unit dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .op_i      (op_i),
        .rs_data_i (rs_data_i),
        .rt_data_i (rt_data_i),
        .hi_we_i   (hi_we_i),
        .lo_we_i   (lo_we_i),
        .wdata_i   (wdata_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .hi_o      (hi_o),
        .lo_o      (lo_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                                          input logic [31:0] cur_hi, input logic [31:0] cur_lo);
        longint      a, b, q, r;
        logic [63:0] p;
        if (op == MULT) begin
            a = longint'($signed(rs));
            b = longint'($signed(rt));
            p = a * b;
        end else if (op == MULTU) begin
            p = {32'b0, rs} * {32'b0, rt};
        end else if (!DIV_EN) begin
            p = {cur_hi, cur_lo};
        end else if (rt == 32'd0) begin
            p = {rs, 32'hFFFF_FFFF};
        end else begin
            if (op == DIV) begin
                a = longint'($signed(rs));
                b = longint'($signed(rt));
            end else begin
                a = longint'({32'b0, rs});
                b = longint'({32'b0, rt});
            end
            q = a / b;
            r = a % b;
            p = {r[31:0], q[31:0]};
        end
        return p;
    endfunction

    function automatic int exp_lat(input logic [1:0] op);
        return (op[1] && !DIV_EN) ? 1 : 34;
    endfunction

    function automatic int exp_busy(input logic [1:0] op);
        return (op[1] && !DIV_EN) ? 0 : 33;
    endfunction

    // Scoreboard: every done_o pops one expected {HI,LO}
    always @(negedge clk) begin
        if (done_o === 1'b1) begin
            logic [63:0] e;
            done_cnt++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: done_o=1 at cycle %0d with nothing pending", cyc);
            end else begin
                e = sb.pop_front();
                if ({hi_o, lo_o} !== e) begin
                    errors++;
                    $display("FAIL result: hi/lo=%h_%h expected %h_%h", hi_o, lo_o, e[63:32], e[31:0]);
                end
            end
        end
    end

    task automatic drive_start(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                               input bit push, output int t0);
        logic [63:0] r;
        @(posedge clk); #1;
        start_i = 1'b1; op_i = op; rs_data_i = rs; rt_data_i = rt;
        t0 = cyc;
        if (push) begin
            r = model(op, rs, rt, m_hi, m_lo);
            sb.push_back(r);
            m_hi = r[63:32];
            m_lo = r[31:0];
        end
        @(posedge clk); #1;
        start_i = 1'b0;
        rs_data_i = $urandom;
        rt_data_i = $urandom;
        op_i = 2'($urandom);
    endtask

    task automatic wait_done(input int t0, output int lat, output int busy_n);
        busy_n = 0;
        lat = -1;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (busy_o === 1'b1) busy_n++;
            if (done_o === 1'b1) begin
                lat = cyc - t0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks += 4;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done_o); end
        if (hi_o !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h want 0", hi_o); end
        if (lo_o !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h want 0", lo_o); end
        @(posedge clk); #1;
        rst_i = 1'b1;
    endtask

    task automatic run_table(input string name, input logic [1:0] ops[], input logic [31:0] rss[],
                             input logic [31:0] rts[]);
        int t0, lat, bn;
        for (int i = 0; i < ops.size(); i++) begin
            drive_start(ops[i], rss[i], rts[i], 1'b1, t0);
            wait_done(t0, lat, bn);
            checks += 2;
            if (lat !== exp_lat(ops[i])) begin
                errors++;
                $display("FAIL %s_latency[%0d]: got %0d want %0d", name, i, lat, exp_lat(ops[i]));
            end
            if (bn !== exp_busy(ops[i])) begin
                errors++;
                $display("FAIL %s_busy_cycles[%0d]: got %0d want %0d", name, i, bn, exp_busy(ops[i]));
            end
        end
    endtask

    task automatic test_mult();
        run_table("mult", '{MULT, MULTU, MULT, MULT},
                  '{32'd7, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF},
                  '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF});
    endtask

    task automatic test_div();
        run_table("div", '{DIV, DIVU, DIV, DIV, DIV, DIVU},
                  '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'd5, 32'hFFFF_FFFB, 32'hFFFF_FFFF},
                  '{32'd2, 32'd2, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'h10});
    endtask

    task automatic test_start_while_busy();
        int t0, t1, lat, bn;
        drive_start(MULT, 32'd3, 32'd4, 1'b1, t0);
        repeat (4) @(posedge clk);
        #1;
        start_i = 1'b1; op_i = DIVU; rs_data_i = 32'd100; rt_data_i = 32'd7;
        t1 = cyc;
        @(posedge clk); #1;
        start_i = 1'b0;
        wait_done(t0, lat, bn);
        checks += 2;
        if (t1 - t0 !== 5) begin errors++; $display("FAIL busy_start_time: got T+%0d want T+5", t1 - t0); end
        if (lat !== 34) begin errors++; $display("FAIL busy_start_latency: got %0d want 34", lat); end
        repeat (40) @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        int t0, dc;
        @(posedge clk); #1;
        hi_we_i = 1'b1; lo_we_i = 1'b1; wdata_i = 32'hAAAA_5555;
        m_hi = 32'hAAAA_5555; m_lo = 32'hAAAA_5555;
        @(posedge clk); #1;
        hi_we_i = 1'b0; lo_we_i = 1'b0;
        dc = done_cnt;
        drive_start(MULT, 32'd9, 32'd9, 1'b0, t0);
        repeat (9) @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(posedge clk); #1;
        rst_i = 1'b1;
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        checks += 5;
        if (cyc - t0 !== 11) begin errors++; $display("FAIL rst_mid_time: got T+%0d want T+11", cyc - t0); end
        if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", busy_o); end
        if (hi_o !== 32'd0) begin errors++; $display("FAIL rst_mid_hi: got %h want 0", hi_o); end
        if (lo_o !== 32'd0) begin errors++; $display("FAIL rst_mid_lo: got %h want 0", lo_o); end
        if (done_o !== 1'b0) begin errors++; $display("FAIL rst_mid_done: got %b want 0", done_o); end
        repeat (40) @(negedge clk);
        checks++;
        if (done_cnt !== dc) begin errors++; $display("FAIL rst_mid_no_done: got %0d pulses want 0", done_cnt - dc); end
    endtask

    task automatic test_mthi_mtlo();
        int t0, lat, bn;
        logic [31:0] lo_before;
        @(posedge clk); #1;
        hi_we_i = 1'b1; wdata_i = 32'h0000_1234;
        @(posedge clk); #1;
        hi_we_i = 1'b0; m_hi = 32'h0000_1234;
        @(negedge clk);
        checks++;
        if (hi_o !== 32'h0000_1234) begin errors++; $display("FAIL mthi_idle: got %h want 00001234", hi_o); end
        lo_before = lo_o;
        drive_start(MULT, 32'd5, 32'd6, 1'b1, t0);
        @(posedge clk); #1;
        lo_we_i = 1'b1; wdata_i = 32'h55;
        @(posedge clk); #1;
        lo_we_i = 1'b0;
        @(negedge clk);
        checks++;
        if (lo_o !== lo_before) begin errors++; $display("FAIL mtlo_busy_dropped: got %h want %h", lo_o, lo_before); end
        wait_done(t0, lat, bn);
        checks++;
        if (lat !== 34) begin errors++; $display("FAIL mtlo_busy_latency: got %0d want 34", lat); end
        // mthi in the same cycle as start: write lands first, result overwrites later
        @(posedge clk); #1;
        start_i = 1'b1; op_i = MULTU; rs_data_i = 32'd2; rt_data_i = 32'd3;
        hi_we_i = 1'b1; wdata_i = 32'h0000_DEAD;
        t0 = cyc;
        sb.push_back(model(MULTU, 32'd2, 32'd3, m_hi, m_lo));
        m_hi = 32'd0; m_lo = 32'd6;
        @(posedge clk); #1;
        start_i = 1'b0; hi_we_i = 1'b0;
        @(negedge clk);
        checks++;
        if (hi_o !== 32'h0000_DEAD) begin errors++; $display("FAIL mthi_with_start: got %h want 0000dead", hi_o); end
        wait_done(t0, lat, bn);
        checks++;
        if (lat !== 34) begin errors++; $display("FAIL mthi_with_start_latency: got %0d want 34", lat); end
    endtask

    task automatic test_back_to_back();
        int t0, lat, bn;
        logic [1:0] op;
        for (int i = 0; i < 8; i++) begin
            op = 2'($urandom_range(0, 3));
            drive_start(op, $urandom, (i == 3) ? 32'd0 : $urandom, 1'b1, t0);
            wait_done(t0, lat, bn);
            checks += 2;
            if (lat !== exp_lat(op)) begin errors++; $display("FAIL b2b_latency[%0d]: got %0d want %0d", i, lat, exp_lat(op)); end
            if (bn !== exp_busy(op)) begin errors++; $display("FAIL b2b_busy[%0d]: got %0d want %0d", i, bn, exp_busy(op)); end
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_start_while_busy();
        test_reset_mid_op();
        test_mthi_mtlo();
        test_back_to_back();
        repeat (5) @(negedge clk);
        checks++;
        if (sb.size() !== 0) begin errors++; $display("FAIL scoreboard_drain: %0d results never produced, want 0", sb.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
